pwm_multichannel: RTL and testbench

- Parametrised successor to the single-channel 10%-step PWM generator.
- Drives N_CH independent PWM outputs from one shared period counter.
- Per-channel duty is adjusted by debounced increment/decrement buttons, routed to the channel chosen by ch_sel.
- Supports edge-aligned and center-aligned modes; duty and mode changes apply only at period boundaries, so outputs never glitch. Sits directly behind the top-level pin wrapper.

---
 rtl/pwm_multichannel_if.sv | 26 ++
 rtl/pwm_multichannel.sv | 151 +++++++++++++++
 tb/tb_pwm_multichannel.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_multichannel_if.sv
// Control/observation bundle for pwm_multichannel: run/mode controls, raw buttons,
// channel select and the PWM outputs with their period marker.
interface pwm_multichannel_if #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned SEL_W = 1
);
    logic                 enable;
    logic                 mode;
    logic [SEL_W-1:0]     ch_sel;
    logic                 inc_btn;
    logic                 dec_btn;
    logic [N_CH-1:0]      pwm_out;
    logic                 period_start;
    logic [CNT_W-1:0]     duty_o;

    modport master (
        output enable, mode, ch_sel, inc_btn, dec_btn,
        input  pwm_out, period_start, duty_o
    );

    modport slave (
        input  enable, mode, ch_sel, inc_btn, dec_btn,
        output pwm_out, period_start, duty_o
    );
endinterface

// File: rtl/pwm_multichannel.sv
// N-channel PWM generator sharing one period counter; per-channel duty is trimmed
// by debounced buttons and shadow-loaded at period boundaries so outputs never glitch.
module pwm_multichannel #(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned PERIOD     = 10,
    parameter int unsigned STEP       = 1,
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned RESET_DUTY = 5,
    parameter int unsigned SEL_W      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_multichannel_if.slave bus
);
    localparam int unsigned EXT_W = CNT_W + 1;
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES);

    // Button path: index 0 = increment, index 1 = decrement
    logic [1:0]            btn_raw_c;
    logic [1:0]            btn_sync1;
    logic [1:0]            btn_sync2;
    logic [1:0]            deb_lvl;
    logic [1:0]            deb_prev;
    logic [1:0][DEB_W-1:0] deb_cnt;
    logic [1:0]            press_c;
    logic                  inc_p_c;
    logic                  dec_p_c;

    logic [N_CH-1:0][CNT_W-1:0] duty_reg;
    logic [N_CH-1:0][CNT_W-1:0] duty_nxt_c;
    logic [N_CH-1:0][CNT_W-1:0] active_duty;
    logic                       active_mode;
    logic [CNT_W-1:0]           duty_sel_c;

    logic [CNT_W-1:0]  cnt;
    logic              cnt_last_c;
    logic [N_CH-1:0]   level_c;
    logic [N_CH-1:0]   pwm_q;
    logic              period_start_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] d);
        logic [EXT_W-1:0] s;
        s = EXT_W'(d) + EXT_W'(STEP);
        return (s > EXT_W'(PERIOD)) ? CNT_W'(PERIOD) : s[CNT_W-1:0];
    endfunction

    // A borrow into the extra top bit means the result went below zero
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] d);
        logic [EXT_W-1:0] s;
        s = EXT_W'(d) - EXT_W'(STEP);
        return s[CNT_W] ? CNT_W'(0) : s[CNT_W-1:0];
    endfunction

    function automatic logic pwm_level(input logic [CNT_W-1:0] d,
                                       input logic [CNT_W-1:0] c,
                                       input logic             center);
        logic [EXT_W-1:0] de;
        logic [EXT_W-1:0] ce;
        logic [EXT_W-1:0] lo;
        de = EXT_W'(d);
        ce = EXT_W'(c);
        lo = (EXT_W'(PERIOD) - de) >> 1;
        return center ? ((ce >= lo) && (ce < (lo + de))) : (ce < de);
    endfunction

    assign btn_raw_c = {bus.dec_btn, bus.inc_btn};

    // Synchronise, then accept a new level only after DEB_CYCLES stable differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync1 <= '0;
            btn_sync2 <= '0;
            deb_lvl   <= '0;
            deb_prev  <= '0;
            deb_cnt   <= '0;
        end else begin
            btn_sync1 <= btn_raw_c;
            btn_sync2 <= btn_sync1;
            deb_prev  <= deb_lvl;
            for (int unsigned b = 0; b < 2; b++) begin
                if (btn_sync2[b] == deb_lvl[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_lvl[b] <= btn_sync2[b];
                    deb_cnt[b] <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + DEB_W'(1);
                end
            end
        end
    end

    assign press_c = deb_lvl & ~deb_prev;
    assign inc_p_c = press_c[0] & ~press_c[1];
    assign dec_p_c = press_c[1] & ~press_c[0];

    // Route presses to the selected channel; out-of-range selects read 0 and do nothing
    always_comb begin
        duty_nxt_c = duty_reg;
        duty_sel_c = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            if (32'(bus.ch_sel) == ch) begin
                duty_sel_c = duty_reg[ch];
                if (inc_p_c) begin
                    duty_nxt_c[ch] = sat_inc(duty_reg[ch]);
                end else if (dec_p_c) begin
                    duty_nxt_c[ch] = sat_dec(duty_reg[ch]);
                end
            end
        end
    end

    assign bus.duty_o = duty_sel_c;
    assign cnt_last_c = (cnt == CNT_W'(PERIOD - 1));

    always_comb begin
        level_c = '0;
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            level_c[ch] = pwm_level(active_duty[ch], cnt, active_mode);
        end
    end

    // Counter, shadow registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            duty_reg       <= {N_CH{CNT_W'(RESET_DUTY)}};
            active_duty    <= {N_CH{CNT_W'(RESET_DUTY)}};
            active_mode    <= 1'b0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            duty_reg <= duty_nxt_c;
            if (bus.enable) begin
                cnt <= cnt_last_c ? '0 : cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
            if (!bus.enable || cnt_last_c) begin
                active_duty <= duty_reg;
                active_mode <= bus.mode;
            end
            pwm_q          <= bus.enable ? level_c : '0;
            period_start_q <= bus.enable && (cnt == '0);
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.period_start = period_start_q;
endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: whole-period waveforms are queued as expectations
// and checked by a monitor that captures each period starting at period_start.
module tb_pwm_multichannel;
    localparam int unsigned N_CH   = 2;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned PERIOD = 10;
    localparam int unsigned SEL_W  = 1;

    typedef logic [N_CH-1:0][PERIOD-1:0] pat_t;
    typedef struct {
        string name;
        pat_t  pat;
    } exp_t;

    // Bit i of a pattern is the output during counter value i
    localparam logic [PERIOD-1:0] P_E4  = 10'b0000001111;
    localparam logic [PERIOD-1:0] P_E5  = 10'b0000011111;
    localparam logic [PERIOD-1:0] P_E6  = 10'b0000111111;
    localparam logic [PERIOD-1:0] P_C4  = 10'b0001111000;
    localparam logic [PERIOD-1:0] P_ON  = 10'b1111111111;
    localparam logic [PERIOD-1:0] P_OFF = 10'b0000000000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pwm_multichannel_if #(.N_CH(N_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

    pwm_multichannel #(
        .N_CH(N_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .STEP(1),
        .DEB_CYCLES(4), .RESET_DUTY(5), .SEL_W(SEL_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic push_exp(input string name, input logic [PERIOD-1:0] p1,
                            input logic [PERIOD-1:0] p0);
        exp_t e;
        e.name = name;
        e.pat  = {p1, p0};
        exp_q.push_back(e);
    endtask

    task automatic wait_ps(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 4 * PERIOD && !seen; k++) begin
            @(negedge clk);
            if (bus.period_start === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no period_start seen, expected one within %0d cycles", name, 4 * PERIOD);
        end
        @(posedge clk);
        #1;
    endtask

    // Queue the waveform for the first period that starts after this call
    task automatic expect_next(input string name, input logic [PERIOD-1:0] p1,
                               input logic [PERIOD-1:0] p0);
        push_exp(name, p1, p0);
        wait_ps(name);
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 4 * PERIOD && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: %0d waveform(s) still pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic i, input logic d, input int hold, input int gap);
        bus.inc_btn = i;
        bus.dec_btn = d;
        repeat (hold) @(posedge clk);
        #1;
        bus.inc_btn = 1'b0;
        bus.dec_btn = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // Capture each period from period_start; compare only periods armed by a queued item
    initial begin : monitor
        pat_t cap;
        exp_t e;
        int   pos;
        bit   armed;
        cap   = '0;
        pos   = -1;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.period_start === 1'b1) begin
                pos   = 0;
                cap   = '0;
                armed = (exp_q.size() > 0);
            end
            if (pos >= 0) begin
                for (int ch = 0; ch < N_CH; ch++) cap[ch][pos] = bus.pwm_out[ch];
                pos++;
                if (pos == PERIOD) begin
                    if (armed) begin
                        e = exp_q.pop_front();
                        n_cmp++;
                        if (cap !== e.pat) begin
                            n_bad++;
                            $display("FAIL %s: waveform ch1=%b ch0=%b, expected ch1=%b ch0=%b",
                                     e.name, cap[1], cap[0], e.pat[1], e.pat[0]);
                        end
                    end
                    pos   = -1;
                    armed = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.enable  = 1'b0;
        bus.mode    = 1'b0;
        bus.ch_sel  = '0;
        bus.inc_btn = 1'b0;
        bus.dec_btn = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pwm", 32'(bus.pwm_out), 0);
        chk("rst_period_start", 32'(bus.period_start), 0);
        chk("rst_duty", 32'(bus.duty_o), 5);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.enable = 1'b1;

        // Default 5/10 on both channels
        expect_next("base_p1", P_E5, P_E5);
        expect_next("base_p2", P_E5, P_E5);

        // Held inc on channel 1: accepted on the 7th edge after first sampling
        bus.ch_sel  = 1'b1;
        bus.inc_btn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("inc_edge6", 32'(bus.duty_o), 5);
        @(posedge clk);
        #1;
        chk("inc_edge7", 32'(bus.duty_o), 6);
        repeat (13) @(posedge clk);
        #1;
        bus.inc_btn = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("inc_release", 32'(bus.duty_o), 6);
        expect_next("ch1_duty6", P_E6, P_E5);
        drain("ch1_duty6");

        // Saturation at PERIOD and at zero
        repeat (6) press(1'b1, 1'b0, 8, 8);
        chk("sat_hi_duty", 32'(bus.duty_o), 10);
        expect_next("sat_hi_wave", P_ON, P_E5);
        drain("sat_hi_wave");
        repeat (12) press(1'b0, 1'b1, 8, 8);
        chk("sat_lo_duty", 32'(bus.duty_o), 0);
        expect_next("sat_lo_wave", P_OFF, P_E5);
        drain("sat_lo_wave");

        // Too-short press and simultaneous buttons change nothing
        bus.ch_sel = 1'b0;
        press(1'b1, 1'b0, 3, 10);
        chk("short_press", 32'(bus.duty_o), 5);
        press(1'b1, 1'b1, 20, 10);
        chk("both_buttons", 32'(bus.duty_o), 5);

        // Channel 0 to duty 4, then edge -> center switch mid-period
        press(1'b0, 1'b1, 8, 8);
        chk("dec_ch0", 32'(bus.duty_o), 4);
        expect_next("edge_d4", P_OFF, P_E4);
        repeat (3) @(posedge clk);
        #1;
        bus.mode = 1'b1;
        expect_next("center_d4", P_OFF, P_C4);
        expect_next("center_d4_again", P_OFF, P_C4);
        drain("center_d4_again");

        // Disable mid-period, change mode while idle, re-enable
        repeat (4) @(posedge clk);
        #1;
        bus.enable = 1'b0;
        @(posedge clk);
        #1;
        chk("dis_pwm", 32'(bus.pwm_out), 0);
        chk("dis_period_start", 32'(bus.period_start), 0);
        bus.mode = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        push_exp("reenable_wave", P_OFF, P_E4);
        bus.enable = 1'b1;
        @(posedge clk);
        #1;
        chk("reen_pwm", 32'(bus.pwm_out), 1);
        chk("reen_period_start", 32'(bus.period_start), 1);
        drain("reenable_wave");

        // Async reset mid-period with inc held through release
        repeat (3) @(posedge clk);
        #1;
        bus.inc_btn = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_pwm", 32'(bus.pwm_out), 0);
        chk("rst_mid_period_start", 32'(bus.period_start), 0);
        chk("rst_mid_duty", 32'(bus.duty_o), 5);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("rehold_edge6", 32'(bus.duty_o), 5);
        @(posedge clk);
        #1;
        chk("rehold_edge7", 32'(bus.duty_o), 6);
        bus.inc_btn = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        expect_next("post_reset", P_E5, P_E6);
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
